// File: rtl/prbs_burst_ctrl.sv
// prbs_burst_ctrl: sequences a PRBS7 generator through seeded bursts
// separated by frozen gaps, and flags which PRBS bits belong to a burst.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start, PRBS frozen
// LOAD   | one cycle: load captured seed into the PRBS
// RUN    | PRBS running, every bit valid, burst_len cycles
// GAP    | PRBS frozen between bursts, gap_len cycles
// DONE   | one-cycle completion pulse, back to IDLE
module prbs_burst_ctrl #(
  parameter int LEN_W = 16,
  parameter int GAP_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [6:0]       seed_i,
  input  logic [LEN_W-1:0] burst_len_i,
  input  logic [GAP_W-1:0] gap_len_i,
  input  logic [CNT_W-1:0] num_bursts_i,
  input  logic             reseed_i,
  output logic [6:0]       lfsr_init_o,
  output logic             load_prbs_o,
  output logic             freeze_o,
  output logic             bit_valid_o,
  output logic [CNT_W-1:0] burst_idx_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [6:0]       r_seed;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_bit_cnt;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] r_bursts_left;
  logic [CNT_W-1:0] r_burst_idx;
  logic             r_reseed;

  logic w_start;
  logic w_bit_last;
  logic w_gap_last;
  logic w_last_burst;
  logic w_next_burst;

  // abort in IDLE also masks a simultaneous start
  assign w_start      = (r_state == S_IDLE) && start_i && !abort_i;
  assign w_bit_last   = (r_bit_cnt == LEN_W'(1));
  assign w_gap_last   = (r_gap_cnt == GAP_W'(1));
  assign w_last_burst = (r_bursts_left == CNT_W'(1));
  assign w_next_burst = (r_state == S_RUN) && w_bit_last && !w_last_burst && !abort_i;

  // state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // next-state decode; abort overrides everything outside IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if ((burst_len_i == '0) || (num_bursts_i == '0)) w_state_nxt = S_DONE;
          else                                             w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_bit_last) begin
          if (w_last_burst)     w_state_nxt = S_DONE;
          else if (r_gap != '0) w_state_nxt = S_GAP;
          else if (r_reseed)    w_state_nxt = S_LOAD;
          else                  w_state_nxt = S_RUN;
        end
      end
      S_GAP: begin
        if (w_gap_last) w_state_nxt = r_reseed ? S_LOAD : S_RUN;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort_i && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
  end

  // config capture and burst/bit/gap down-counters (terminal count 1)
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_seed        <= 7'h7f;
      r_len         <= '0;
      r_gap         <= '0;
      r_reseed      <= 1'b0;
      r_bit_cnt     <= '0;
      r_gap_cnt     <= '0;
      r_bursts_left <= '0;
      r_burst_idx   <= '0;
    end else begin
      if (w_start) begin
        r_seed        <= (seed_i == 7'h00) ? 7'h7f : seed_i;
        r_len         <= burst_len_i;
        r_gap         <= gap_len_i;
        r_reseed      <= reseed_i;
        r_bursts_left <= num_bursts_i;
        r_burst_idx   <= '0;
      end
      case (r_state)
        S_LOAD: r_bit_cnt <= r_len;
        S_RUN: begin
          if (w_bit_last) begin
            r_bit_cnt <= r_len;
            r_gap_cnt <= r_gap;
          end else begin
            r_bit_cnt <= r_bit_cnt - LEN_W'(1);
          end
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          if (w_gap_last) r_bit_cnt <= r_len;
        end
        default: ;
      endcase
      if (w_next_burst) begin
        r_bursts_left <= r_bursts_left - CNT_W'(1);
        r_burst_idx   <= r_burst_idx + CNT_W'(1);
      end
    end
  end

  assign lfsr_init_o = r_seed;
  assign load_prbs_o = (r_state == S_LOAD);
  assign freeze_o    = (r_state != S_RUN);
  assign bit_valid_o = (r_state == S_RUN);
  assign busy_o      = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_GAP);
  assign done_o      = (r_state == S_DONE);
  assign burst_idx_o = r_burst_idx;

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// tb_prbs_burst_ctrl: directed bench for prbs_burst_ctrl with a reference
// PRBS7 driven by the controller and a queue of expected burst bits.
module tb_prbs_burst_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        abort_i;
  logic [6:0]  seed_i;
  logic [15:0] burst_len_i;
  logic [7:0]  gap_len_i;
  logic [7:0]  num_bursts_i;
  logic        reseed_i;
  logic [6:0]  lfsr_init_o;
  logic        load_prbs_o;
  logic        freeze_o;
  logic        bit_valid_o;
  logic [7:0]  burst_idx_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  logic exp_q[$];
  logic [6:0] m_lfsr = 7'h7f;

  prbs_burst_ctrl dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .seed_i       (seed_i),
    .burst_len_i  (burst_len_i),
    .gap_len_i    (gap_len_i),
    .num_bursts_i (num_bursts_i),
    .reseed_i     (reseed_i),
    .lfsr_init_o  (lfsr_init_o),
    .load_prbs_o  (load_prbs_o),
    .freeze_o     (freeze_o),
    .bit_valid_o  (bit_valid_o),
    .burst_idx_o  (burst_idx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  // reference PRBS7 (x^7 + x^6 + 1), output is the MSB
  always @(posedge clk_i) begin
    if (load_prbs_o === 1'b1)     m_lfsr <= lfsr_init_o;
    else if (freeze_o === 1'b0)   m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every valid bit must match the next expected PRBS bit
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && bit_valid_o === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) check("prbs_q_underflow", 32'd1, 32'd0);
      else                   check("prbs_bit", {31'd0, m_lfsr[6]}, {31'd0, exp_q.pop_front()});
    end
  end

  function automatic logic [6:0] prbs_next(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  task automatic push_bits(input logic [6:0] seed, input int len, input int nb, input bit rs);
    logic [6:0] s;
    s = seed;
    for (int b = 0; b < nb; b++) begin
      if (rs) s = seed;
      for (int i = 0; i < len; i++) begin
        exp_q.push_back(s[6]);
        s = prbs_next(s);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // runs one full sequence and checks timing, load/freeze counts and bits
  task automatic run_seq(input string tag, input logic [6:0] seed, input int len,
                         input int gap, input int nb, input bit rs);
    int done_at, loads, frz, v0, exp_done, exp_loads, exp_frz;
    bit degen;
    logic [6:0] seff;
    degen = (len == 0) || (nb == 0);
    seff  = (seed == 7'h00) ? 7'h7f : seed;
    if (!degen) push_bits(seff, len, nb, rs);
    if (degen)   exp_done = 1;
    else if (rs) exp_done = 1 + nb * (1 + len) + (nb - 1) * gap;
    else         exp_done = 2 + nb * len + (nb - 1) * gap;
    exp_loads = degen ? 0 : (rs ? nb : 1);
    exp_frz   = degen ? 0 : (exp_loads + (nb - 1) * gap);
    done_at = -1; loads = 0; frz = 0; v0 = n_valid;
    seed_i = seed; burst_len_i = len[15:0]; gap_len_i = gap[7:0];
    num_bursts_i = nb[7:0]; reseed_i = rs; start_i = 1'b1;
    step();
    start_i = 1'b0;
    if (!degen) begin
      check({tag, "_load_first"}, {31'd0, load_prbs_o}, 32'd1);
      check({tag, "_idx_start"}, {24'd0, burst_idx_o}, 32'd0);
    end
    for (int k = 1; k <= exp_done + 5; k++) begin
      if (done_o) begin done_at = k; break; end
      if (load_prbs_o) begin
        loads++;
        check({tag, "_seed"}, {25'd0, lfsr_init_o}, {25'd0, seff});
      end
      if (freeze_o) frz++;
      step();
    end
    check({tag, "_done_cycle"}, done_at, exp_done);
    check({tag, "_loads"}, loads, exp_loads);
    check({tag, "_freeze_cycles"}, frz, exp_frz);
    check({tag, "_valid_count"}, n_valid - v0, len * nb);
    check({tag, "_busy_at_done"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_idx_end"}, {24'd0, burst_idx_o}, degen ? 32'd0 : nb - 1);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    step();
    check({tag, "_done_one_cycle"}, {31'd0, done_o}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_lfsr_init"}, {25'd0, lfsr_init_o}, 32'h7f);
    check({tag, "_load"}, {31'd0, load_prbs_o}, 32'd0);
    check({tag, "_freeze"}, {31'd0, freeze_o}, 32'd1);
    check({tag, "_valid"}, {31'd0, bit_valid_o}, 32'd0);
    check({tag, "_idx"}, {24'd0, burst_idx_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_done"}, {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; seed_i = 7'h00;
    burst_len_i = '0; gap_len_i = '0; num_bursts_i = '0; reseed_i = 1'b0;
    step(); step();
    check_reset_vals("reset");
    rst_ni = 1'b1;
    step();

    run_seq("single", 7'h7f, 8, 0, 1, 1'b1);
    run_seq("gap_reseed", 7'h7f, 3, 2, 2, 1'b1);
    run_seq("b2b_cont", 7'h5a, 4, 0, 2, 1'b0);
    run_seq("gap_cont", 7'h25, 5, 3, 3, 1'b0);
    run_seq("gap_max", 7'h13, 2, 255, 2, 1'b0);
    run_seq("b2b_reseed", 7'h41, 3, 0, 3, 1'b1);
    run_seq("len0", 7'h11, 0, 2, 3, 1'b1);
    run_seq("nb0", 7'h11, 5, 2, 0, 1'b0);
    run_seq("seed0", 7'h00, 9, 1, 2, 1'b1);

    // abort in the third RUN cycle, with an ignored start mid-burst
    push_bits(7'h33, 3, 1, 1'b1);
    seed_i = 7'h33; burst_len_i = 16'd10; gap_len_i = 8'd0;
    num_bursts_i = 8'd2; reseed_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    check("abort_pre_valid", {31'd0, bit_valid_o}, 32'd1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_freeze", {31'd0, freeze_o}, 32'd1);
    check("abort_valid", {31'd0, bit_valid_o}, 32'd0);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      if (done_o || load_prbs_o || busy_o) seen++;
      step();
    end
    check("abort_quiet", seen, 0);
    check("abort_q_empty", exp_q.size(), 0);

    // abort together with start in IDLE keeps IDLE
    start_i = 1'b1; abort_i = 1'b1;
    step();
    start_i = 1'b0; abort_i = 1'b0;
    check("abort_start_busy", {31'd0, busy_o}, 32'd0);
    check("abort_start_load", {31'd0, load_prbs_o}, 32'd0);
    check("abort_start_done", {31'd0, done_o}, 32'd0);
    step();

    // reset during GAP
    push_bits(7'h15, 3, 1, 1'b1);
    seed_i = 7'h15; burst_len_i = 16'd3; gap_len_i = 8'd5;
    num_bursts_i = 8'd2; reseed_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("mid_gap_busy", {31'd0, busy_o}, 32'd1);
    check("mid_gap_idx", {24'd0, burst_idx_o}, 32'd1);
    rst_ni = 1'b0;
    step();
    check_reset_vals("mid_reset");
    rst_ni = 1'b1;
    step();
    check("mid_reset_q_empty", exp_q.size(), 0);

    run_seq("after_reset", 7'h6c, 6, 1, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
